// File: rtl/regfile_block_xfer_seq.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list, issuing one memory
// word request per register and driving the register-file ports for loads and base writeback.
module regfile_block_xfer_seq #(
    parameter int DATA_W = 32,
    parameter int RNUM_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic [15:0]       reg_list,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [3:0]        base_reg,
    input  logic              up,
    input  logic              pre,
    input  logic              wback,
    output logic              busy,
    output logic              done,
    output logic [RNUM_W-1:0] rf_read_reg_num,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [RNUM_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_regwrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_XFER   = 3'd1;
    localparam logic [2:0] S_LWR    = 3'd2;
    localparam logic [2:0] S_BASEWB = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        r_state;
    logic [15:0]       r_mask;
    logic              r_is_load;
    logic              r_do_wb;
    logic [3:0]        r_base_reg;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wb_val;
    logic [DATA_W-1:0] r_ld_data;
    logic [3:0]        r_ld_reg;

    logic [4:0]        w_count;
    logic [DATA_W-1:0] w_span;
    logic [DATA_W-1:0] w_start_addr;
    logic [DATA_W-1:0] w_wb_val;
    logic [3:0]        w_cur;
    logic [15:0]       w_mask_next;

    always_comb begin
        w_count = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_count = w_count + {4'd0, reg_list[i]};
        end
        w_span = DATA_W'({w_count, 2'b00});
        case ({up, pre})
            2'b10:   w_start_addr = base_addr;
            2'b11:   w_start_addr = base_addr + DATA_W'(4);
            2'b00:   w_start_addr = base_addr - w_span + DATA_W'(4);
            default: w_start_addr = base_addr - w_span;
        endcase
        w_wb_val = up ? (base_addr + w_span) : (base_addr - w_span);
    end

    // Lowest remaining register is always the one at the current (lowest) address.
    always_comb begin
        w_cur = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_mask[i]) w_cur = 4'(i);
        end
        w_mask_next = r_mask & ~(16'd1 << w_cur);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= (w_count == 5'd0) ? S_DONE : S_XFER;
                end
                S_XFER: begin
                    if (mem_ack) begin
                        if (r_is_load)                r_state <= S_LWR;
                        else if (w_mask_next != 16'd0) r_state <= S_XFER;
                        else                          r_state <= r_do_wb ? S_BASEWB : S_DONE;
                    end
                end
                S_LWR: begin
                    if (r_mask != 16'd0) r_state <= S_XFER;
                    else                 r_state <= r_do_wb ? S_BASEWB : S_DONE;
                end
                S_BASEWB: r_state <= S_DONE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath holds no reset; every consumer is gated by r_state.
    always_ff @(posedge clock) begin
        if (r_state == S_IDLE && start) begin
            r_mask     <= reg_list;
            r_is_load  <= is_load;
            r_do_wb    <= wback & ~(is_load & reg_list[base_reg]);
            r_base_reg <= base_reg;
            r_addr     <= w_start_addr;
            r_wb_val   <= w_wb_val;
        end else if (r_state == S_XFER && mem_ack) begin
            r_mask    <= w_mask_next;
            r_addr    <= r_addr + DATA_W'(4);
            r_ld_data <= mem_rdata;
            r_ld_reg  <= w_cur;
        end
    end

    always_comb begin
        busy            = (r_state != S_IDLE);
        done            = (r_state == S_DONE);
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        rf_read_reg_num = '0;
        rf_write_reg    = '0;
        rf_write_data   = '0;
        rf_regwrite     = 1'b0;
        case (r_state)
            S_XFER: begin
                mem_req  = 1'b1;
                mem_we   = ~r_is_load;
                mem_addr = r_addr;
                if (!r_is_load) begin
                    rf_read_reg_num = {{(RNUM_W-4){1'b0}}, w_cur};
                    mem_wdata       = rf_read_data;
                end
            end
            S_LWR: begin
                rf_regwrite   = 1'b1;
                rf_write_reg  = {{(RNUM_W-4){1'b0}}, r_ld_reg};
                rf_write_data = r_ld_data;
            end
            S_BASEWB: begin
                rf_regwrite   = 1'b1;
                rf_write_reg  = {{(RNUM_W-4){1'b0}}, r_base_reg};
                rf_write_data = r_wb_val;
            end
            default: ;
        endcase
    end

endmodule
